dbg_access_arb: RTL
===================

# dbg_access_arb

Round-robin arbiter and sequencer that shares one debug access port (enable/read/write, address, bank, data in/out, valid) among NREQ requesters (JTAG bridge, CPU register path, BIST, scrubber). It takes one transaction at a time, issues a one-cycle command to the debug port, waits for read data on `dbg_vld`, and returns a completion to the owning requester. It sits between the requester agents and the memory macro's debug port.

## Interface
- NREQ, 4, number of requesters (2..8)
- DBGADDRWIDTH, 7, debug address width
- DBGBADDRWIDTH, 7, debug bank select width
- DBGDATAWIDTH, 144, debug data width
- TIMEOUT, 64, read wait limit in cycles (used only with DBG_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req_vld  in  NREQ  per-requester request; held until its ack
- req_write  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*DBGADDRWIDTH  flattened addresses, requester i at slice i
- req_bank  in  NREQ*DBGBADDRWIDTH  flattened bank selects
- req_din  in  NREQ*DBGDATAWIDTH  flattened write data
- req_ack  out  NREQ  one-hot, one-cycle completion pulse
- rsp_dout  out  DBGDATAWIDTH  read data, valid with req_ack
- rsp_err  out  1  timeout flag, valid with req_ack
- dbg_en, dbg_read, dbg_write  out  1 each  debug command strobes
- dbg_addr  out  DBGADDRWIDTH;  dbg_bank  out  DBGBADDRWIDTH;  dbg_din  out  DBGDATAWIDTH
- dbg_vld  in  1  read data valid
- dbg_dout  in  DBGDATAWIDTH  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req_vld, select the first set bit at or after rr_ptr (wrapping), latch owner, write, addr, bank, din, then go to ISSUE.
- ISSUE: one cycle with dbg_en=1 and dbg_read=~write, dbg_write=write. Write goes to DONE. Read goes to WAIT and clears the timeout counter.
- WAIT: on dbg_vld, capture dbg_dout into rsp_dout, rsp_err=0, go to DONE. dbg_vld is ignored in every other state.
- DONE: req_ack[owner]=1 for one cycle, rr_ptr=owner+1 mod NREQ, go to IDLE. Writes leave rsp_dout unchanged and rsp_err=0.
- Requesters that deassert req_vld before their ack produce undefined behaviour; the bench flags it with an assertion.
- Reset (any state, including WAIT): all outputs 0, rr_ptr=0, state IDLE. A late dbg_vld after reset is ignored.

## Timing
- All dbg_* and rsp_* outputs are registered.
- Request first seen in IDLE at cycle 0: dbg_en is high at cycle 1 and is never high on consecutive cycles.
- Write: ack at cycle 2. Minimum issue spacing is 3 cycles.
- Read with dbg_vld in cycle k≥2: ack and rsp_dout in cycle k+1. If the memory returns dbg_vld in cycle 2, the ack is at cycle 3.
- The arbiter samples the next request in IDLE, one cycle after DONE. There is no back-to-back grant without a passing IDLE.
- dbg_addr, dbg_bank and dbg_din hold their last values outside ISSUE. Only the strobes return to 0.

## Configuration
- DBG_ARB_TIMEOUT_EN defined: WAIT counts cycles. When the count reaches TIMEOUT with no dbg_vld, the FSM goes to DONE with rsp_err=1 and rsp_dout=0. The counter is $clog2(TIMEOUT+1) bits and saturates.
- DBG_ARB_TIMEOUT_EN undefined: no counter, and WAIT is exited only by dbg_vld. rsp_err is tied to 0.

## Structure
- Shared package dbg_pkg holds the state enum typedef (IDLE/ISSUE/WAIT/DONE) and a command struct (write, addr, bank, din), parameterized by localparams that match the defaults.
- One sub-module, dbg_rr_pick: a combinational round-robin picker with inputs req[NREQ] and ptr, and outputs a one-hot grant and an index.

## Test plan
- Single read: req_vld=4'b0001 to addr 7'h12, bank 3, with dbg_vld and dbg_dout=144'hA5 at cycle 4. Required: dbg_en/dbg_read at cycle 1 with addr 12/bank 3, then req_ack=0001 and rsp_dout=A5 at cycle 5.
- Write: req 2 writes din=144'h1234 to addr 7'h05. Required: dbg_write=1 and dbg_din=1234 at cycle 1, req_ack=0100 at cycle 2, no dbg_read.
- Contention: req_vld=4'b1111 held, all writes. Required: ack order 0,1,2,3,0 with dbg_en exactly once per 3 cycles.
- Timeout (macro on, TIMEOUT=8): read with no dbg_vld. Required: ack with rsp_err=1 and rsp_dout=0 exactly 8 cycles after entering WAIT. With the macro off, no ack appears within 100 cycles.
- Reset mid-WAIT: assert rst_n=0 in WAIT, then pulse dbg_vld after release. Required: all outputs 0 immediately, no ack, and the next request is served by requester 0 first.
- Stray valid: dbg_vld=1 during IDLE and during a write ISSUE. Required: no ack and rsp_dout unchanged.

Source files
------------

// File: rtl/dbg_pkg.sv
// ---------------------------------------------------------------------------
// dbg_pkg
// Shared types for the debug access arbiter.
//   dbg_state_t : sequencer states (IDLE, ISSUE, WAIT, DONE)
//   dbg_cmd_t   : one debug command (write flag, address, bank, write data)
// The localparams give the default widths of the debug port.
// ---------------------------------------------------------------------------
package dbg_pkg;

    localparam int DBG_NREQ_DEF    = 4;
    localparam int DBG_ADDR_W      = 7;
    localparam int DBG_BANK_W      = 7;
    localparam int DBG_DATA_W      = 144;
    localparam int DBG_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } dbg_state_t;

    typedef struct packed {
        logic                  write;
        logic [DBG_ADDR_W-1:0] addr;
        logic [DBG_BANK_W-1:0] bank;
        logic [DBG_DATA_W-1:0] din;
    } dbg_cmd_t;

endpackage

// File: rtl/dbg_rr_pick.sv
// ---------------------------------------------------------------------------
// dbg_rr_pick
// Combinational round-robin picker: returns the first set request bit at or
// after ptr, wrapping around past NREQ-1.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IDXW  search start position (0..NREQ-1)
//   grant out NREQ  one-hot grant (all zero when req is zero)
//   idx   out IDXW  index of the granted bit (0 when req is zero)
// ---------------------------------------------------------------------------
module dbg_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx
);

    logic            found;
    logic [IDXW-1:0] pos;
    int              j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            // Walk positions ptr, ptr+1, ... modulo NREQ.
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            pos = IDXW'(j);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/dbg_access_arb.sv
// ---------------------------------------------------------------------------
// dbg_access_arb
// Round-robin arbiter/sequencer sharing one memory debug port among NREQ
// requesters. One transaction at a time: latch the winner's command in IDLE,
// strobe the debug port for one cycle in ISSUE, wait for read data in WAIT,
// pulse the owner's ack in DONE.
//
// Optional feature macro: DBG_ARB_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT cycles, acking with rsp_err=1 and
//               rsp_dout=0.
//   undefined : WAIT is left only on dbg_vld; rsp_err is constant 0.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_vld/write     per-requester request and direction (1=write)
//   req_addr/bank/din flattened per-requester command fields (slice i)
//   req_ack           one-hot, one-cycle completion pulse
//   rsp_dout/rsp_err  read data / timeout flag, valid with req_ack
//   dbg_en/read/write debug command strobes (one cycle, registered)
//   dbg_addr/bank/din debug command fields (registered, held between issues)
//   dbg_vld/dbg_dout  read data return from the debug port
// ---------------------------------------------------------------------------
module dbg_access_arb
    import dbg_pkg::*;
#(
    parameter int NREQ          = DBG_NREQ_DEF,
    parameter int DBGADDRWIDTH  = DBG_ADDR_W,
    parameter int DBGBADDRWIDTH = DBG_BANK_W,
    parameter int DBGDATAWIDTH  = DBG_DATA_W,
    parameter int TIMEOUT       = DBG_TIMEOUT_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NREQ-1:0]                 req_vld,
    input  logic [NREQ-1:0]                 req_write,
    input  logic [NREQ*DBGADDRWIDTH-1:0]    req_addr,
    input  logic [NREQ*DBGBADDRWIDTH-1:0]   req_bank,
    input  logic [NREQ*DBGDATAWIDTH-1:0]    req_din,
    output logic [NREQ-1:0]                 req_ack,
    output logic [DBGDATAWIDTH-1:0]         rsp_dout,
    output logic                            rsp_err,
    output logic                            dbg_en,
    output logic                            dbg_read,
    output logic                            dbg_write,
    output logic [DBGADDRWIDTH-1:0]         dbg_addr,
    output logic [DBGBADDRWIDTH-1:0]        dbg_bank,
    output logic [DBGDATAWIDTH-1:0]         dbg_din,
    input  logic                            dbg_vld,
    input  logic [DBGDATAWIDTH-1:0]         dbg_dout
);

    localparam int IDXW = $clog2(NREQ);

    // ------------------------------------------------------------------
    // Unflatten the per-requester command buses.
    // ------------------------------------------------------------------
    logic [DBGADDRWIDTH-1:0]  addr_arr [NREQ];
    logic [DBGBADDRWIDTH-1:0] bank_arr [NREQ];
    logic [DBGDATAWIDTH-1:0]  din_arr  [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign addr_arr[gi] = req_addr[gi*DBGADDRWIDTH  +: DBGADDRWIDTH];
        assign bank_arr[gi] = req_bank[gi*DBGBADDRWIDTH +: DBGBADDRWIDTH];
        assign din_arr[gi]  = req_din [gi*DBGDATAWIDTH  +: DBGDATAWIDTH];
    end

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    dbg_state_t       state_reg;
    logic [IDXW-1:0]  rr_ptr_reg;
    logic [IDXW-1:0]  owner_idx_reg;
    logic [NREQ-1:0]  owner_oh_reg;
    logic [NREQ-1:0]  pick_grant;
    logic [IDXW-1:0]  pick_idx;
    logic             pick_write;

    dbg_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req   (req_vld),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign pick_write = req_write[pick_idx];

`ifdef DBG_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Read wait counter, saturating at all-ones.
    // ------------------------------------------------------------------
    localparam int CNTW = $clog2(TIMEOUT + 1);

    logic [CNTW-1:0] wait_cnt_reg;
    logic [CNTW-1:0] wait_cnt_next;

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (wait_cnt_reg != {CNTW{1'b1}}) begin
            wait_cnt_next = wait_cnt_reg + CNTW'(1);
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign rsp_err        = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer. All port outputs are registered here; the strobes and
    // the ack default low so each is a single-cycle pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_idx_reg <= '0;
            owner_oh_reg  <= '0;
            req_ack       <= '0;
            rsp_dout      <= '0;
            dbg_en        <= 1'b0;
            dbg_read      <= 1'b0;
            dbg_write     <= 1'b0;
            dbg_addr      <= '0;
            dbg_bank      <= '0;
            dbg_din       <= '0;
`ifdef DBG_ARB_TIMEOUT_EN
            rsp_err       <= 1'b0;
            wait_cnt_reg  <= '0;
`endif
        end else begin
            dbg_en    <= 1'b0;
            dbg_read  <= 1'b0;
            dbg_write <= 1'b0;
            req_ack   <= '0;

            case (state_reg)
                IDLE: begin
                    if (|req_vld) begin
                        // Latch the winner's command straight onto the
                        // debug port so the strobe lands in ISSUE.
                        owner_idx_reg <= pick_idx;
                        owner_oh_reg  <= pick_grant;
                        dbg_addr      <= addr_arr[pick_idx];
                        dbg_bank      <= bank_arr[pick_idx];
                        dbg_din       <= din_arr[pick_idx];
                        dbg_en        <= 1'b1;
                        dbg_read      <= ~pick_write;
                        dbg_write     <= pick_write;
                        state_reg     <= ISSUE;
                    end
                end

                ISSUE: begin
                    // dbg_write still holds the latched direction here.
                    if (dbg_write) begin
                        req_ack   <= owner_oh_reg;
`ifdef DBG_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state_reg <= DONE;
                    end else begin
`ifdef DBG_ARB_TIMEOUT_EN
                        wait_cnt_reg <= '0;
`endif
                        state_reg <= WAIT;
                    end
                end

                WAIT: begin
                    if (dbg_vld) begin
                        rsp_dout  <= dbg_dout;
                        req_ack   <= owner_oh_reg;
`ifdef DBG_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state_reg <= DONE;
                    end
`ifdef DBG_ARB_TIMEOUT_EN
                    else begin
                        wait_cnt_reg <= wait_cnt_next;
                        if (wait_cnt_next >= CNTW'(TIMEOUT)) begin
                            rsp_dout  <= '0;
                            rsp_err   <= 1'b1;
                            req_ack   <= owner_oh_reg;
                            state_reg <= DONE;
                        end
                    end
`endif
                end

                DONE: begin
                    // Next search starts just after the requester served.
                    if (owner_idx_reg == IDXW'(NREQ - 1)) begin
                        rr_ptr_reg <= '0;
                    end else begin
                        rr_ptr_reg <= owner_idx_reg + IDXW'(1);
                    end
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
